// File: rtl/multi_chan_xform_pipe_if.sv
// Streaming interface for multi_chan_xform_pipe.
//   in_valid / in_ready   : producer-side handshake
//   in_data               : NUM_CH channels of W bits, channel c at [c*W +: W]
//   in_mode               : 2-bit mode per channel, channel c at [2c +: 2]
//   out_valid / out_ready : consumer-side handshake
//   out_data              : transformed channels, same packing as in_data
// The master modport is the side that drives the beats in and consumes them out (the bench);
// the slave modport is the transform block itself.
interface multi_chan_xform_pipe_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned W      = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_CH*W-1:0]    in_data;
    logic [2*NUM_CH-1:0]    in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_CH*W-1:0]    out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/multi_chan_xform_pipe.sv
// Multi-channel bitwise transform followed by a STAGES-deep valid/ready pipeline.
// Each of NUM_CH channels (W bits) is passed, inverted, bit-reversed or zeroed according to its
// own 2-bit mode, sampled together with the data in the accept cycle. Results move through a
// registered pipeline with full backpressure and bubble collapsing; completed output transfers
// are counted modulo 2^CNT_W.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : streaming interface (slave modport), see multi_chan_xform_pipe_if
//   xfer_count : number of completed output transfers, wraps silently
module multi_chan_xform_pipe #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned W      = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_chan_xform_pipe_if.slave      bus,
    output logic [CNT_W-1:0]            xfer_count
);

    localparam int unsigned DW = NUM_CH * W;

    logic [STAGES-1:0] v_q;
    logic [DW-1:0]     d_q [STAGES];
    logic [STAGES-1:0] rdy;
    logic [DW-1:0]     xf;
    logic [CNT_W-1:0]  xfer_count_q;

    // Per-channel transform of the incoming beat.
    logic [W-1:0] ch;
    logic [W-1:0] rev;
    always_comb begin
        xf  = '0;
        ch  = '0;
        rev = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            ch = bus.in_data[c*W +: W];
            for (int i = 0; i < int'(W); i++) begin
                rev[i] = ch[int'(W) - 1 - i];
            end
            case (bus.in_mode[2*c +: 2])
                2'b00:   xf[c*W +: W] = ch;
                2'b01:   xf[c*W +: W] = ~ch;
                2'b10:   xf[c*W +: W] = rev;
                default: xf[c*W +: W] = '0;
            endcase
        end
    end

    // Ready ripples back from the consumer; an empty stage is always ready, so bubbles collapse.
    logic r;
    always_comb begin
        rdy = '0;
        r   = !v_q[STAGES-1] || bus.out_ready;
        rdy[STAGES-1] = r;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                d_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    d_q[0] <= xf;
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_q[k-1];
                    // Data only moves with a valid beat so an idle output keeps its last value.
                    if (v_q[k-1]) begin
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
        end else if (v_q[STAGES-1] && bus.out_ready) begin
            xfer_count_q <= xfer_count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_data  = d_q[STAGES-1];
    assign xfer_count    = xfer_count_q;

endmodule

// File: doc/multi_chan_xform_pipe.md
Name: multi_chan_xform_pipe

Overview:
- Parametrised multi-channel bitwise transform stage.
- Generalises the single-width combinational inverter to NUM_CH channels of W bits each, with a per-channel runtime mode: pass, invert, bit-reverse or zero.
- Results travel through a STAGES-deep registered valid/ready pipeline that supports backpressure.
- Sits between a producer and a consumer on a streaming datapath and counts completed output transfers.

Parameters:
- NUM_CH, 2, number of independent channels (>=1).
- W, 4, bits per channel (>=1).
- STAGES, 2, pipeline register stages (>=1); sets the latency.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  NUM_CH*W  channel c occupies bits [c*W +: W].
- in_mode  input  2*NUM_CH  channel c mode at bits [2c +: 2]: 00 pass, 01 invert, 10 bit-reverse, 11 zero.
- out_valid  output  1  output beat available.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  NUM_CH*W  transformed channels, same packing as in_data.
- xfer_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Behaviour:
- Reset is synchronous: sampled on the rising clk edge while rst_n=0.
  - Every stage valid bit clears, out_valid=0 and xfer_count=0.
  - Stage data registers and out_data clear to 0.
  - Reset mid-stream discards all in-flight beats; nothing is emitted after release.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_valid and in_data are not required to be held stable; only the transfer cycle is sampled.
  - out_data is held stable while out_valid && !out_ready.
- Transform:
  - Applied combinationally to in_data, using in_mode sampled in the same accept cycle, and registered into stage 0.
  - Mode changes never affect beats already accepted.
  - Invert: bitwise NOT of the channel.
  - Bit-reverse: result bit i = input bit W-1-i within the channel; W=1 is identical to pass.
  - Zero: channel forced to 0.
  - Channels are fully independent; there is no carry or cross-channel mixing.
- Pipeline:
  - Stage k holds v[k] and d[k]; out_valid=v[STAGES-1] and out_data=d[STAGES-1].
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready.
  - rdy[k] = !v[k] || rdy[k+1] for k < STAGES-1.
  - in_ready = rdy[0] (combinational from out_ready; no registered skid).
  - When rdy[k] is set, stage k loads from stage k-1 (stage 0 loads from the transform); v[k] takes the upstream valid.
- Latency and throughput:
  - A beat accepted at edge n is presented with out_valid at cycle n+STAGES, provided out_ready was held 1.
  - Sustained throughput is 1 beat/clk with out_ready=1.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Full condition: all v=1 and out_ready=0, so in_ready=0; no beat is dropped or duplicated.
- Simultaneous events: when full and out_ready=1, an input is accepted in the same cycle; occupancy stays constant.
- Empty condition: out_valid=0; out_data holds its last value and is don't-care.
- xfer_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Otherwise holds its value.
- Ordering: beats emerge strictly in acceptance order.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clks, then release with in_valid=0 -> out_valid=0, in_ready=1, xfer_count=0, out_data=0.
- Modes and latency (defaults): in_data=8'hA3, in_mode=4'b0110 (ch0 bit-reverse, ch1 invert), out_ready=1 -> out_data=8'h5C (ch0 4'h3 reverses to 4'hC, ch1 4'hA inverts to 4'h5) exactly 2 clks after accept; then mode=4'b1100 with data 8'hA3 -> out_data=8'h03.
- Backpressure: stream 6 beats 8'h01..8'h06 in pass mode, out_ready=0 for cycles 2-7:
  - in_ready drops to 0 once 2 beats are held.
  - After out_ready returns to 1, all 6 beats arrive in order with no loss or duplication.
  - xfer_count=6.
- Full plus simultaneous: with the pipeline full, assert in_valid=1 and out_ready=1 on the same cycle -> one beat out, one beat in, out_valid stays 1 and occupancy stays 2.
- Counter wrap: 257 transfers with CNT_W=8 -> xfer_count=1.
- Reset mid-operation:
  - Pipeline full with out_ready=0; pulse rst_n=0 for 1 clk -> out_valid=0 on the next cycle and the held beats are never emitted.
  - A new beat after release emerges with the normal 2-clk latency.
